jt12_acc_n: RTL and testbench

Parametrised successor to the six-channel FM output accumulator. It takes the time-multiplexed operator stream from the operator unit and sums carrier operators per channel according to each channel's algorithm. It applies an optional per-channel limiter, PCM substitution on the last channel and per-channel L/R panning, then mixes all channels into saturated stereo samples, one per frame. It sits between the operator unit and the board-level audio mixer/filter, for chips with CH channels of 4 operators.

---
 rtl/jt12_acc_n.sv | 157 +++++++++++++++
 tb/tb_jt12_acc_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_acc_n.sv
// Per-channel carrier accumulator and stereo mixer for a CH-channel, 4-operator FM core.
// Consumes the time-multiplexed operator stream and emits one saturated L/R sample per frame.
module jt12_acc_n #(
    parameter int CH   = 6,
    parameter int OPW  = 9,
    parameter int OUTW = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   zero,
    input  logic [OPW-1:0]         op_result,
    input  logic [3*CH-1:0]        alg,
    input  logic [2*CH-1:0]        rl,
    input  logic                   limiter_en,
    input  logic                   pcm_en,
    input  logic [OPW-1:0]         pcm,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample,
    output logic                   sync_err
);
    localparam int AW = OPW + 2;
    localparam int CW = $clog2(CH);
    localparam int MW = AW + $clog2(CH);

    localparam logic signed [AW-1:0] OP_MAX = AW'(2**(OPW-1) - 1);
    localparam logic signed [AW-1:0] OP_MIN = AW'(-(2**(OPW-1)));

    // Slot counter split into operator position and channel; holds the index expected next.
    logic [1:0]    pos_reg;
    logic [CW-1:0] ch_reg;
    logic          first_reg;
    logic          mix_pend_reg;

    logic [1:0]    cur_pos;
    logic [CW-1:0] cur_ch;
    logic [2:0]    cur_alg;
    logic          carrier;
    logic          last_slot;
    logic          frame_start;

    logic signed [AW-1:0]   op_ext;
    logic [2:0]             alg_ch [CH];
    logic [CH*MW-1:0]       v_flat;
    logic signed [MW-1:0]   sum_l;
    logic signed [MW-1:0]   sum_r;
    logic signed [OUTW-1:0] left_next;
    logic signed [OUTW-1:0] right_next;

    assign cur_pos     = zero ? 2'd0 : pos_reg;
    assign cur_ch      = zero ? '0 : ch_reg;
    assign cur_alg     = alg_ch[cur_ch];
    assign last_slot   = (cur_pos == 2'd3) && (cur_ch == CW'(CH - 1));
    assign frame_start = (pos_reg == 2'd0) && (ch_reg == '0);
    assign op_ext      = AW'($signed(op_result));

    always_comb begin
        carrier = 1'b0;
        case (cur_pos)
            2'd0:    carrier = (cur_alg == 3'd7);
            2'd1:    carrier = (cur_alg >= 3'd5);
            2'd2:    carrier = (cur_alg >= 3'd4);
            default: carrier = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic signed [AW-1:0] acc_reg;
            logic signed [AW-1:0] lim_val;
            logic signed [AW-1:0] ch_val;

            assign alg_ch[gi] = alg[3*gi +: 3];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (cen && (cur_ch == CW'(gi))) begin
                    if (cur_pos == 2'd0)
                        acc_reg <= carrier ? op_ext : '0;
                    else if (carrier)
                        acc_reg <= acc_reg + op_ext;
                end
            end

            assign lim_val = (acc_reg > OP_MAX) ? OP_MAX :
                             (acc_reg < OP_MIN) ? OP_MIN : acc_reg;
            // The last channel's accumulator keeps running under PCM but is simply not used.
            assign ch_val  = ((gi == CH - 1) && pcm_en) ? AW'($signed(pcm)) :
                             limiter_en ? lim_val : acc_reg;
            assign v_flat[gi*MW +: MW] = MW'(ch_val);
        end
    endgenerate

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < CH; i++) begin
            if (rl[2*i+1]) sum_l = sum_l + $signed(v_flat[i*MW +: MW]);
            if (rl[2*i])   sum_r = sum_r + $signed(v_flat[i*MW +: MW]);
        end
    end

    generate
        if (OUTW >= MW) begin : g_ext
            assign left_next  = OUTW'(sum_l);
            assign right_next = OUTW'(sum_r);
        end else begin : g_sat
            localparam logic signed [MW-1:0] OUT_MAX = MW'(2**(OUTW-1) - 1);
            localparam logic signed [MW-1:0] OUT_MIN = MW'(-(2**(OUTW-1)));
            assign left_next  = (sum_l > OUT_MAX) ? OUTW'(OUT_MAX) :
                                (sum_l < OUT_MIN) ? OUTW'(OUT_MIN) : OUTW'(sum_l);
            assign right_next = (sum_r > OUT_MAX) ? OUTW'(OUT_MAX) :
                                (sum_r < OUT_MIN) ? OUTW'(OUT_MIN) : OUTW'(sum_r);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg      <= 2'd0;
            ch_reg       <= '0;
            first_reg    <= 1'b1;
            mix_pend_reg <= 1'b0;
            sample       <= 1'b0;
            sync_err     <= 1'b0;
            left         <= '0;
            right        <= '0;
        end else begin
            sync_err     <= 1'b0;
            mix_pend_reg <= 1'b0;
            sample       <= mix_pend_reg;
            // Mix reads the accumulators before any slot-0 overwrite on this same edge.
            if (mix_pend_reg) begin
                left  <= left_next;
                right <= right_next;
            end
            if (cen) begin
                if (zero) begin
                    first_reg <= 1'b0;
                    if (!first_reg && !frame_start)
                        sync_err <= 1'b1;
                end
                // Frames run before the first zero are unsynchronised and never mixed.
                if (last_slot && !first_reg)
                    mix_pend_reg <= 1'b1;
                if (cur_ch == CW'(CH - 1)) begin
                    ch_reg  <= '0;
                    pos_reg <= cur_pos + 2'd1;
                end else begin
                    ch_reg  <= cur_ch + CW'(1);
                    pos_reg <= cur_pos;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt12_acc_n.sv
// Randomised and directed bench for jt12_acc_n against a frame-level arithmetic model.
module tb_jt12_acc_n;
    localparam int CH   = 6;
    localparam int OPW  = 9;
    localparam int OUTW = 12;
    localparam int NS   = 4 * CH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cen = 1'b0;
    logic                   zero = 1'b0;
    logic [OPW-1:0]         op_result = '0;
    logic [3*CH-1:0]        alg = '0;
    logic [2*CH-1:0]        rl = '0;
    logic                   limiter_en = 1'b0;
    logic                   pcm_en = 1'b0;
    logic [OPW-1:0]         pcm = '0;
    logic signed [OUTW-1:0] left;
    logic signed [OUTW-1:0] right;
    logic                   sample;
    logic                   sync_err;

    int n_vec = 0;
    int n_bad = 0;
    int samp_cnt = 0;
    int sync_cnt = 0;
    int ops [NS];
    int pcm_val = 0;

    jt12_acc_n #(.CH(CH), .OPW(OPW), .OUTW(OUTW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_result(op_result),
        .alg(alg), .rl(rl), .limiter_en(limiter_en), .pcm_en(pcm_en), .pcm(pcm),
        .left(left), .right(right), .sample(sample), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample)   samp_cnt++;
        if (sync_err) sync_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_carrier(input int a, input int p);
        case (p)
            0:       return a == 7;
            1:       return a == 5 || a == 6 || a == 7;
            2:       return a >= 4;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int sat(input int x, input int lo, input int hi);
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    // Slot k carries operator position k/CH of channel k%CH.
    task automatic model(output int el, output int er);
        int s;
        el = 0;
        er = 0;
        for (int c = 0; c < CH; c++) begin
            s = 0;
            for (int p = 0; p < 4; p++)
                if (is_carrier(int'(alg[3*c +: 3]), p)) s += ops[p*CH + c];
            if (limiter_en) s = sat(s, -(2**(OPW-1)), 2**(OPW-1) - 1);
            if (pcm_en && c == CH - 1) s = pcm_val;
            if (rl[2*c+1]) el += s;
            if (rl[2*c])   er += s;
        end
        el = sat(el, -(2**(OUTW-1)), 2**(OUTW-1) - 1);
        er = sat(er, -(2**(OUTW-1)), 2**(OUTW-1) - 1);
    endtask

    task automatic slot(input int op, input bit z);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        cen = 1'b1;
        zero = z;
        op_result = OPW'(op);
        @(posedge clk);
        #1;
        cen = 1'b0;
        zero = 1'b0;
    endtask

    task automatic frame(input string tag, input int exp_sync);
        int el, er;
        samp_cnt = 0;
        sync_cnt = 0;
        pcm = OPW'(pcm_val);
        for (int k = 0; k < NS; k++) slot(ops[k], k == 0);
        chk({tag, "_early"}, int'(sample), 0);
        @(posedge clk);
        #1;
        chk({tag, "_lat"}, int'(sample), 1);
        model(el, er);
        chk({tag, "_L"}, int'(left), el);
        chk({tag, "_R"}, int'(right), er);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_nsamp"}, samp_cnt, 1);
        chk({tag, "_nsync"}, sync_cnt, exp_sync);
        $display("frame %s: L=%0d R=%0d (model %0d/%0d)", tag, left, right, el, er);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NS; k++) ops[k] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NS; k++) ops[k] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic set_alg(input int a);
        for (int c = 0; c < CH; c++) alg[3*c +: 3] = 3'(a);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", int'(left), 0);
        chk("rst_right", int'(right), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_sync", int'(sync_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rl = '1;
        set_alg(7);
        fill(10);
        frame("all10", 0);
        chk("all10_L", int'(left), 240);
        chk("all10_R", int'(right), 240);

        fill(255);
        frame("pos_sat", 0);
        chk("pos_sat_L", int'(left), 2047);
        fill(-256);
        frame("neg_sat", 0);
        chk("neg_sat_R", int'(right), -2048);

        set_alg(0);
        for (int k = 0; k < NS; k++) ops[k] = (k >= 3*CH) ? 7 : 100;
        frame("alg0", 0);
        chk("alg0_L", int'(left), 42);
        set_alg(4);
        for (int k = 2*CH; k < 3*CH; k++) ops[k] = 5;
        frame("alg4", 0);
        chk("alg4_R", int'(right), 72);

        set_alg(7);
        fill(0);
        for (int p = 0; p < 4; p++) ops[p*CH] = 255;
        limiter_en = 1'b1;
        frame("lim_on", 0);
        chk("lim_on_L", int'(left), 255);
        limiter_en = 1'b0;
        rl[1:0] = 2'b10;
        frame("lim_off", 0);
        chk("lim_off_L", int'(left), 1020);
        chk("lim_off_R", int'(right), 0);

        rl = '1;
        fill(0);
        for (int p = 0; p < 4; p++) ops[p*CH + CH - 1] = 200;
        pcm_en = 1'b1;
        pcm_val = -50;
        frame("pcm", 0);
        chk("pcm_L", int'(left), -50);
        pcm_en = 1'b0;

        // Early zero at slot 10 aborts the partial frame; the following frame must be clean.
        fill_rand();
        for (int k = 0; k < 10; k++) slot(ops[k], k == 0);
        fill_rand();
        frame("abort", 1);

        // Reset mid-frame, then let the counter free-run until zero resynchronises it.
        for (int k = 0; k < 15; k++) slot(ops[k], k == 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_left", int'(left), 0);
        chk("mrst_sample", int'(sample), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        samp_cnt = 0;
        sync_cnt = 0;
        for (int k = 15; k < NS; k++) slot(ops[k], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_nosamp", samp_cnt, 0);
        chk("mrst_right", int'(right), 0);
        fill_rand();
        frame("resync", 0);

        for (int f = 0; f < 20; f++) begin
            fill_rand();
            alg = 3*CH'($urandom);
            rl = 2*CH'($urandom);
            limiter_en = 1'($urandom);
            pcm_en = 1'($urandom);
            pcm_val = int'($urandom_range(0, 511)) - 256;
            frame($sformatf("rnd%0d", f), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
